// File: rtl/term_pkg.sv
// Shared definitions for the terminal writer: ASCII controls, screen geometry,
// FSM state encoding and VRAM cell address packing.
package term_pkg;

  localparam int COLS = 64;
  localparam int ROWS = 32;

  localparam logic [7:0] BLANK = 8'h20;

  localparam logic [7:0] ASCII_BEL = 8'h07;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_FF  = 8'h0C;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_DEL = 8'h7F;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  localparam logic [5:0]  X_MAX       = 6'(COLS - 1);
  localparam logic [4:0]  Y_MAX       = 5'(ROWS - 1);
  localparam logic [10:0] ADDR_MAX    = 11'(COLS * ROWS - 1);
  localparam logic [10:0] SCROLL_SRC0 = 11'(COLS);
  localparam logic [10:0] LAST_ROW    = 11'((ROWS - 1) * COLS);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_PUT,
    ST_CTRL,
    ST_SCR_RD,
    ST_SCR_WR,
    ST_SCR_CLR
  } state_t;

  function automatic logic [10:0] cell_addr(input logic [4:0] y, input logic [5:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/term_bel_timer.sv
// Visual-bell timer: o_bel is high for BEL_CYCLES clocks after the last load.
// Load takes effect on the same edge; a load while running restarts the count.
module term_bel_timer #(
  parameter int unsigned BEL_CYCLES = 2400000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_bel
);

  localparam int CW = $clog2(BEL_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
      o_bel <= 1'b0;
    end else if (i_load) begin
      count <= CW'(BEL_CYCLES);
      o_bel <= 1'b1;
    end else if (count != '0) begin
      count <= count - 1'b1;
      o_bel <= (count > CW'(1));
    end
  end

endmodule

// File: rtl/term_writer.sv
// Terminal writer: decodes ASCII into 64x32 VRAM cell writes, cursor moves, scroll and clear.
// A byte is accepted only in IDLE (one per visit); o_ready is low for every busy clock.
module term_writer
  import term_pkg::*;
#(
  parameter int unsigned BEL_CYCLES = 2400000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [10:0] o_vram_addr,
  output logic [7:0]  o_vram_din,
  input  logic [7:0]  i_vram_dout,
  output logic        o_vram_ce,
  output logic        o_vram_wre,
  output logic        o_bel
);

  state_t      state;
  logic [5:0]  cur_x;
  logic [4:0]  cur_y;
  logic [10:0] src;
  logic [7:0]  din_q;
  logic        accept;
  logic        bel_load;
  logic [5:0]  tab_or;

  assign accept   = i_valid && o_ready;
  assign bel_load = accept && (i_data == ASCII_BEL);
  assign tab_or   = cur_x | 6'd7;

  // The copy write must carry the byte read on the previous clock, so the
  // read data passes straight through while in SCR_WR.
  assign o_vram_din = (state == ST_SCR_WR) ? i_vram_dout : din_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_CLEAR;
      cur_x       <= '0;
      cur_y       <= '0;
      src         <= '0;
      din_q       <= BLANK;
      o_vram_addr <= '0;
      o_vram_ce   <= 1'b0;
      o_vram_wre  <= 1'b0;
      o_ready     <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (!o_vram_wre) begin
            // first clock after reset: the fill starts from cell 0
            o_vram_addr <= '0;
            din_q       <= BLANK;
            o_vram_ce   <= 1'b1;
            o_vram_wre  <= 1'b1;
          end else if (o_vram_addr == ADDR_MAX) begin
            cur_x       <= '0;
            cur_y       <= '0;
            o_vram_addr <= cell_addr(5'd0, 6'd0);
            o_vram_wre  <= 1'b0;
            o_ready     <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            o_vram_addr <= o_vram_addr + 11'd1;
          end
        end

        ST_IDLE: begin
          if (accept) begin
            o_ready <= 1'b0;
            if (i_data >= PRINT_LO && i_data <= PRINT_HI) begin
              din_q      <= i_data;
              o_vram_wre <= 1'b1;
              state      <= ST_PUT;
            end else begin
              state <= ST_CTRL;
              case (i_data)
                ASCII_CR:  cur_x <= '0;
                ASCII_LF: begin
                  if (cur_y < Y_MAX) begin
                    cur_y <= cur_y + 5'd1;
                  end else begin
                    src         <= SCROLL_SRC0;
                    o_vram_addr <= SCROLL_SRC0;
                    state       <= ST_SCR_RD;
                  end
                end
                ASCII_BS: begin
                  if (cur_x != 6'd0) cur_x <= cur_x - 6'd1;
                end
                ASCII_TAB: cur_x <= (tab_or == X_MAX) ? X_MAX : tab_or + 6'd1;
                ASCII_FF: begin
                  o_vram_addr <= '0;
                  din_q       <= BLANK;
                  o_vram_wre  <= 1'b1;
                  state       <= ST_CLEAR;
                end
                ASCII_DEL: ;
                default:   ;
              endcase
            end
          end
        end

        ST_PUT: begin
          o_vram_wre <= 1'b0;
          if (cur_x < X_MAX) begin
            cur_x       <= cur_x + 6'd1;
            o_vram_addr <= cell_addr(cur_y, cur_x + 6'd1);
            o_ready     <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cur_x <= '0;
            if (cur_y < Y_MAX) begin
              cur_y       <= cur_y + 5'd1;
              o_vram_addr <= cell_addr(cur_y + 5'd1, 6'd0);
              o_ready     <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              src         <= SCROLL_SRC0;
              o_vram_addr <= SCROLL_SRC0;
              state       <= ST_SCR_RD;
            end
          end
        end

        ST_CTRL: begin
          o_vram_addr <= cell_addr(cur_y, cur_x);
          o_ready     <= 1'b1;
          state       <= ST_IDLE;
        end

        ST_SCR_RD: begin
          o_vram_addr <= src - SCROLL_SRC0;
          o_vram_wre  <= 1'b1;
          state       <= ST_SCR_WR;
        end

        ST_SCR_WR: begin
          if (src == ADDR_MAX) begin
            o_vram_addr <= LAST_ROW;
            din_q       <= BLANK;
            state       <= ST_SCR_CLR;
          end else begin
            src         <= src + 11'd1;
            o_vram_addr <= src + 11'd1;
            o_vram_wre  <= 1'b0;
            state       <= ST_SCR_RD;
          end
        end

        ST_SCR_CLR: begin
          if (o_vram_addr == ADDR_MAX) begin
            o_vram_addr <= cell_addr(cur_y, cur_x);
            o_vram_wre  <= 1'b0;
            o_ready     <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            o_vram_addr <= o_vram_addr + 11'd1;
          end
        end

        default: begin
          o_vram_wre <= 1'b0;
          o_ready    <= 1'b0;
          state      <= ST_CLEAR;
        end
      endcase
    end
  end

  term_bel_timer #(
    .BEL_CYCLES(BEL_CYCLES)
  ) u_bel (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (bel_load),
    .o_bel  (o_bel)
  );

endmodule

// File: tb/tb_term_writer.sv
// Bench for term_writer: directed scenarios plus a random byte stream checked
// against a screen/cursor model, with a behavioural VRAM attached to port A.
module tb_term_writer;

  localparam int unsigned BEL_T = 10;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_data = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [10:0] o_vram_addr;
  logic [7:0]  o_vram_din;
  logic [7:0]  i_vram_dout;
  logic        o_vram_ce;
  logic        o_vram_wre;
  logic        o_bel;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram     [0:2047];
  logic [7:0] pre     [0:2047];
  logic [7:0] exp_mem [0:2047];
  logic       preload = 1'b0;
  int         mx, my;

  term_writer #(.BEL_CYCLES(BEL_T)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_vram_addr (o_vram_addr),
    .o_vram_din  (o_vram_din),
    .i_vram_dout (i_vram_dout),
    .o_vram_ce   (o_vram_ce),
    .o_vram_wre  (o_vram_wre),
    .o_bel       (o_bel)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous single-port VRAM: read data appears one clock after the address.
  always @(posedge i_clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) ram[i] <= pre[i];
    end else if (o_vram_ce) begin
      if (o_vram_wre) ram[o_vram_addr] <= o_vram_din;
      else            i_vram_dout <= ram[o_vram_addr];
    end
  end

  task automatic model_newline();
    if (my < 31) my++;
    else begin
      for (int a = 0; a < 1984; a++) exp_mem[a] = exp_mem[a + 64];
      for (int a = 1984; a < 2048; a++) exp_mem[a] = 8'h20;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int t;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_mem[my * 64 + mx] = b;
      if (mx < 63) mx++;
      else begin mx = 0; model_newline(); end
    end else begin
      case (b)
        8'h0D: mx = 0;
        8'h0A: model_newline();
        8'h08: if (mx > 0) mx--;
        8'h09: begin t = (mx / 8 + 1) * 8; mx = (t > 63) ? 63 : t; end
        default: ;
      endcase
    end
  endtask

  task automatic start_byte(input logic [7:0] b);
    int n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 5000) begin @(negedge i_clk); n++; end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout byte %02h", b);
    end
    i_data = b;
    i_valid = 1'b1;
  endtask

  task automatic xfer(input logic [7:0] b, output int nwr, output logic [10:0] waddr,
                      output logic [7:0] wdat, output int cyc);
    nwr = 0; waddr = '0; wdat = '0; cyc = 0;
    start_byte(b);
    for (int k = 0; k < 5000; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      if (o_vram_ce && o_vram_wre) begin nwr++; waddr = o_vram_addr; wdat = o_vram_din; end
      if (o_ready) break;
      cyc++;
    end
    if (!o_ready) begin
      checks++; errors++;
      $display("FAIL xfer_timeout byte %02h", b);
    end
  endtask

  task automatic check_clear(input string name);
    int nwr = 0;
    int bad = 0;
    for (int k = 0; k < 2100; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      if (o_vram_ce && o_vram_wre) begin
        if (o_vram_addr !== 11'(nwr) || o_vram_din !== 8'h20) bad++;
        nwr++;
      end
    end
    checks++; if (nwr !== 2048) begin errors++; $display("FAIL %s_writes got %0d want 2048", name, nwr); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL %s_order got %0d bad writes want 0", name, bad); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL %s_ready got %b want 1", name, o_ready); end
    checks++; if (o_vram_addr !== 11'd0) begin errors++; $display("FAIL %s_addr got %0d want 0", name, o_vram_addr); end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++; if (o_vram_addr !== 11'd0) begin errors++; $display("FAIL %s_addr got %0d want 0", name, o_vram_addr); end
    checks++; if (o_vram_din !== 8'h20) begin errors++; $display("FAIL %s_din got %02h want 20", name, o_vram_din); end
    checks++; if (o_vram_ce !== 1'b0) begin errors++; $display("FAIL %s_ce got %b want 0", name, o_vram_ce); end
    checks++; if (o_vram_wre !== 1'b0) begin errors++; $display("FAIL %s_wre got %b want 0", name, o_vram_wre); end
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL %s_ready got %b want 0", name, o_ready); end
    checks++; if (o_bel !== 1'b0) begin errors++; $display("FAIL %s_bel got %b want 0", name, o_bel); end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
  endtask

  task automatic test_clear();
    i_rst = 1'b0;
    check_clear("clear");
  endtask

  task automatic test_put();
    int nwr, cyc;
    logic [10:0] wa;
    logic [7:0] wd;
    xfer(8'h41, nwr, wa, wd, cyc);
    checks++; if (nwr !== 1 || wa !== 11'd0 || wd !== 8'h41) begin errors++; $display("FAIL put_a got n=%0d a=%0d d=%02h want n=1 a=0 d=41", nwr, wa, wd); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL put_busy got %0d want 1", cyc); end
    xfer(8'h42, nwr, wa, wd, cyc);
    checks++; if (nwr !== 1 || wa !== 11'd1 || wd !== 8'h42) begin errors++; $display("FAIL put_b got n=%0d a=%0d d=%02h want n=1 a=1 d=42", nwr, wa, wd); end
    checks++; if (o_vram_addr !== 11'd2) begin errors++; $display("FAIL put_cursor got %0d want 2", o_vram_addr); end
    xfer(8'h0D, nwr, wa, wd, cyc);
    checks++; if (o_vram_addr !== 11'd0 || nwr !== 0) begin errors++; $display("FAIL cr got a=%0d n=%0d want a=0 n=0", o_vram_addr, nwr); end
    xfer(8'h0A, nwr, wa, wd, cyc);
    checks++; if (o_vram_addr !== 11'd64) begin errors++; $display("FAIL lf got %0d want 64", o_vram_addr); end
  endtask

  task automatic test_wrap();
    int nwr, cyc;
    logic [10:0] wa;
    logic [7:0] wd;
    int tab_exp [8];
    tab_exp = '{8, 16, 24, 32, 40, 48, 56, 63};
    start_byte(8'h0C);
    check_clear("ff_clear");
    for (int i = 0; i < 5; i++) xfer(8'h0A, nwr, wa, wd, cyc);
    checks++; if (o_vram_addr !== 11'd320) begin errors++; $display("FAIL lf5 got %0d want 320", o_vram_addr); end
    for (int i = 0; i < 8; i++) begin
      xfer(8'h09, nwr, wa, wd, cyc);
      checks++;
      if (o_vram_addr !== 11'(320 + tab_exp[i])) begin
        errors++; $display("FAIL tab%0d got %0d want %0d", i, o_vram_addr, 320 + tab_exp[i]);
      end
    end
    xfer(8'h5A, nwr, wa, wd, cyc);
    checks++; if (nwr !== 1 || wa !== 11'd383 || wd !== 8'h5A) begin errors++; $display("FAIL wrap_put got n=%0d a=%0d d=%02h want n=1 a=383 d=5a", nwr, wa, wd); end
    checks++; if (o_vram_addr !== 11'd384) begin errors++; $display("FAIL wrap_cursor got %0d want 384", o_vram_addr); end
  endtask

  task automatic test_bs();
    int nwr, cyc;
    logic [10:0] wa;
    logic [7:0] wd;
    xfer(8'h08, nwr, wa, wd, cyc);
    checks++; if (nwr !== 0 || o_vram_addr !== 11'd384) begin errors++; $display("FAIL bs_x0 got n=%0d a=%0d want n=0 a=384", nwr, o_vram_addr); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL ctrl_busy got %0d want 1", cyc); end
    xfer(8'h71, nwr, wa, wd, cyc);
    xfer(8'h08, nwr, wa, wd, cyc);
    checks++; if (nwr !== 0 || o_vram_addr !== 11'd384) begin errors++; $display("FAIL bs_back got n=%0d a=%0d want n=0 a=384", nwr, o_vram_addr); end
  endtask

  task automatic test_bel();
    int hi = 0;
    bit resent = 1'b0;
    checks++; if (o_bel !== 1'b0) begin errors++; $display("FAIL bel_idle got %b want 0", o_bel); end
    start_byte(8'h07);
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      if (o_bel) hi++;
      else if (hi > 0) break;
    end
    checks++; if (hi !== int'(BEL_T)) begin errors++; $display("FAIL bel_len got %0d want %0d", hi, BEL_T); end
    hi = 0;
    start_byte(8'h07);
    for (int k = 0; k < 100; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      if (o_bel) hi++;
      else if (hi > 0) break;
      if (hi == 5 && !resent) begin
        resent = 1'b1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bel_resend_ready got %b want 1", o_ready); end
        i_data = 8'h07;
        i_valid = 1'b1;
      end
    end
    checks++; if (hi !== 5 + int'(BEL_T)) begin errors++; $display("FAIL bel_extend got %0d want %0d", hi, 5 + BEL_T); end
  endtask

  task automatic test_scroll();
    int nwr, cyc, busy;
    logic [10:0] wa;
    logic [7:0] wd;
    int bad0, bad30, bad31, badmid;
    xfer(8'h0D, nwr, wa, wd, cyc);
    for (int i = 0; i < 25; i++) xfer(8'h0A, nwr, wa, wd, cyc);
    checks++; if (o_vram_addr !== 11'd1984) begin errors++; $display("FAIL bottom_row got %0d want 1984", o_vram_addr); end
    for (int a = 0; a < 2048; a++) pre[a] = 8'(8'h30 + a / 64);
    @(negedge i_clk); preload = 1'b1;
    @(negedge i_clk); preload = 1'b0;
    start_byte(8'h0A);
    busy = 0;
    for (int k = 0; k < 4200; k++) begin
      @(negedge i_clk);
      i_data = 8'h51;
      if (o_ready) break;
      busy++;
    end
    checks++; if (busy !== 4032) begin errors++; $display("FAIL scroll_busy got %0d want 4032", busy); end
    bad0 = 0; bad30 = 0; bad31 = 0; badmid = 0;
    for (int a = 0; a < 2048; a++) begin
      if (a < 64)        begin if (ram[a] !== 8'h31) bad0++; end
      else if (a < 1920) begin if (ram[a] !== 8'(8'h31 + a / 64)) badmid++; end
      else if (a < 1984) begin if (ram[a] !== 8'h4F) bad30++; end
      else               begin if (ram[a] !== 8'h20) bad31++; end
    end
    checks++; if (bad0 !== 0) begin errors++; $display("FAIL scroll_row0 got %0d bad cells want 0", bad0); end
    checks++; if (badmid !== 0) begin errors++; $display("FAIL scroll_mid got %0d bad cells want 0", badmid); end
    checks++; if (bad30 !== 0) begin errors++; $display("FAIL scroll_row30 got %0d bad cells want 0", bad30); end
    checks++; if (bad31 !== 0) begin errors++; $display("FAIL scroll_row31 got %0d bad cells want 0", bad31); end
    @(negedge i_clk);
    i_valid = 1'b0;
    checks++; if (!(o_vram_ce && o_vram_wre) || o_vram_addr !== 11'd1984 || o_vram_din !== 8'h51) begin
      errors++; $display("FAIL held_put got a=%0d d=%02h wre=%b want a=1984 d=51 wre=1", o_vram_addr, o_vram_din, o_vram_wre);
    end
    @(negedge i_clk);
    checks++; if (o_ready !== 1'b1 || o_vram_addr !== 11'd1985) begin errors++; $display("FAIL held_cursor got r=%b a=%0d want r=1 a=1985", o_ready, o_vram_addr); end
  endtask

  task automatic test_reset_mid_scroll();
    bit found = 1'b0;
    start_byte(8'h0A);
    for (int k = 0; k < 3000; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      if (o_vram_ce && !o_vram_wre && o_vram_addr == 11'd500) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_scroll_src500 got 0 want 1"); end
    i_rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    check_clear("rst_clear");
  endtask

  task automatic test_random();
    int nwr, cyc, r, bad;
    logic [10:0] wa;
    logic [7:0] wd;
    logic [7:0] b;
    logic [7:0] others [4];
    others = '{8'h00, 8'h7F, 8'h1B, 8'h01};
    mx = 0; my = 0;
    for (int a = 0; a < 2048; a++) exp_mem[a] = 8'h20;
    for (int i = 0; i < 29; i++) begin xfer(8'h0A, nwr, wa, wd, cyc); model_byte(8'h0A); end
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(32, 126));
      else if (r < 70) b = 8'h0A;
      else if (r < 76) b = 8'h0D;
      else if (r < 82) b = 8'h08;
      else if (r < 90) b = 8'h09;
      else if (r < 93) b = 8'h07;
      else             b = others[$urandom_range(0, 3)];
      xfer(b, nwr, wa, wd, cyc);
      model_byte(b);
      checks++;
      if (o_vram_addr !== 11'(my * 64 + mx)) begin
        errors++; $display("FAIL rand_cursor step %0d byte %02h got %0d want %0d", i, b, o_vram_addr, my * 64 + mx);
      end
    end
    bad = 0;
    for (int a = 0; a < 2048; a++) if (ram[a] !== exp_mem[a]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_screen got %0d bad cells want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_put();
    test_wrap();
    test_bs();
    test_bel();
    test_scroll();
    test_reset_mid_scroll();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/term_writer.md
Name: term_writer

Overview:
- Terminal controller on the writer side of the character VRAM. It is the port A client of the video block.
- Accepts ASCII bytes over a valid/ready handshake, interprets printable and control characters, and writes cells into the 64x32 VRAM.
- Maintains the cursor and exposes it as the idle VRAM address, which the video block uses for its cursor.
- Scrolls the screen by VRAM copy and drives the visual-bell (reverse video) request.

Parameters:
- COLS, 64, characters per row (fixed by VRAM map; x is 6 bits)
- ROWS, 32, rows (y is 5 bits)
- BLANK, 8'h20, fill character for clear and scroll
- BEL_CYCLES, 2400000, o_bel high time in clocks (0.2 s at 12 MHz)

Ports:
- i_clk  in  1  system clock (12 MHz); also clocks VRAM port A
- i_rst  in  1  asynchronous, active-high reset
- i_data  in  8  input character
- i_valid  in  1  i_data valid
- o_ready  out  1  block can accept a character this cycle
- o_vram_addr  out  11  VRAM address {y[4:0], x[5:0]}
- o_vram_din  out  8  VRAM write data
- i_vram_dout  in  8  VRAM read data, valid 1 clock after address with ce
- o_vram_ce  out  1  VRAM clock enable
- o_vram_wre  out  1  1 = write, 0 = read
- o_bel  out  1  reverse-video request

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high. All state is registered.
- Reset values: o_vram_addr 0, o_vram_din 8'h20, o_vram_ce 0, o_vram_wre 0, o_ready 0, o_bel 0, cursor x=0 y=0, state CLEAR, bell counter 0.
- Reset asserted mid-operation (scroll, clear, put) aborts that operation immediately. It restarts in CLEAR after release.
- Handshake: a byte is accepted when i_valid && o_ready. o_ready = 1 only in IDLE. i_data is sampled on the accept edge. At most one byte is accepted per IDLE visit.
- IDLE outputs: o_vram_addr = {y,x}, o_vram_ce = 1, o_vram_wre = 0. The cursor position is therefore always visible on the address bus when idle.
- State CLEAR: writes BLANK to addresses 0..2047, one per clock (wre=1, ce=1). Then sets cursor to 0,0 and goes to IDLE. Takes 2048 clocks.
- State IDLE, on accept, byte decode:
  - 0x20..0x7E: go to PUT.
  - 0x0D (CR): x=0.
  - 0x0A (LF): call NEWLINE.
  - 0x08 (BS): x=x-1 if x>0, else no change; no erase.
  - 0x09 (TAB): x = (x|7)+1, clamped to 63.
  - 0x07 (BEL): load bell counter with BEL_CYCLES.
  - 0x0C (FF): go to CLEAR.
  - All other bytes, including 0x7F: ignored.
  - Non-FF control bytes return to IDLE on the next clock. o_ready drops for 1 clock.
- State PUT: one clock. addr={y,x}, din=byte, wre=1. Then:
  - if x<63, x=x+1;
  - else x=0 and call NEWLINE.
- NEWLINE: if y<31, y=y+1 and go to IDLE. If y=31, go to SCR_RD with src=64 (y stays 31).
- Scroll states:
  - SCR_RD: addr=src, wre=0.
  - SCR_WR: addr=src-64, din=i_vram_dout, wre=1. Then src+1. If src was 2047, go to SCR_CLR with dst=1984.
  - SCR_CLR: write BLANK at dst, dst+1, until 2047. Then go to IDLE.
  - Total scroll time: 1984*2 + 64 = 4032 clocks.
- Bell: the counter decrements to 0 every clock. o_bel = (counter != 0). A BEL received while the bell is active reloads the counter.
- Arithmetic: x is 6-bit and y is 5-bit, with explicit compares at the limits; no implicit wrap is relied on. The src/dst counters are 11-bit.

Decomposition:
- Shared package (term_pkg): ASCII control constants (CR, LF, BS, TAB, BEL, FF, DEL), COLS/ROWS, BLANK, the state enumeration, and the address-packing function {y,x}.
- One sub-module: term_bel_timer, the bell counter. It has a load input and the o_bel output.
- The FSM and scroll engine stay in term_writer.

Test Plan:
- Reset then idle 2100 clocks: exactly 2048 writes of 0x20 to addresses 0..2047. Then o_ready=1 and o_vram_addr=0.
- Send "AB": writes 0x41 at addr 0 and 0x42 at addr 1; idle o_vram_addr=2. Send CR then LF: o_vram_addr=64.
- Cursor at x=63 y=5, send 'Z': write 0x5A at addr 383. Cursor then {6,0} = addr 384.
- Scroll:
  - Preload the VRAM model with row r = 8'h30+r. Set cursor y=31 and send LF.
  - Required response: row 0 = 0x31, row 30 = 0x4F, row 31 = 0x20, all within 4032 clocks.
  - o_ready stays 0 throughout the scroll; i_valid held high is not accepted until the scroll completes.
- Send BEL with BEL_CYCLES overridden to 10: o_bel high for exactly 10 clocks. BEL resent at clock 5 extends o_bel to clock 15. BS at x=0: address unchanged, no write.
- Assert i_rst during scroll (src=500): outputs return to reset values asynchronously. After release, a full 2048-cell CLEAR runs and the cursor is at 0.
